// File: rtl/csr_pkg.sv
// Shared constants and state type for the machine-mode trap sequencer.
// CSR addresses, mstatus bit positions, interrupt cause codes, FSM states.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int MS_MIE  = 3;
  localparam int MS_MPIE = 7;
  localparam int MS_MPP_LO = 11;
  localparam int MS_MPP_HI = 12;

  localparam logic [4:0] IRQ_MSI = 5'd3;
  localparam logic [4:0] IRQ_MTI = 5'd7;
  localparam logic [4:0] IRQ_MEI = 5'd11;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WR_EPC      = 3'd1,
    ST_WR_CAUSE    = 3'd2,
    ST_WR_STATUS   = 3'd3,
    ST_MRET_STATUS = 3'd4,
    ST_REDIRECT    = 3'd5
  } trap_state_t;

endpackage

// File: rtl/trap_arbiter.sv
// Combinational priority pick: exception > MEI > MSI > MTI > MRET.
// Ports: requests + enables in; take/is_irq/is_mret/code out.
module trap_arbiter
  import csr_pkg::*;
(
  input  logic       exc_req,
  input  logic [4:0] exc_code,
  input  logic       mret_req,
  input  logic       irq_ext,
  input  logic       irq_sw,
  input  logic       irq_timer,
  input  logic       gie,
  input  logic       mie_ext,
  input  logic       mie_sw,
  input  logic       mie_timer,
  output logic       take,
  output logic       is_irq,
  output logic       is_mret,
  output logic [4:0] code
);

  logic e_ext;
  logic e_sw;
  logic e_tim;

  assign e_ext = gie & irq_ext & mie_ext;
  assign e_sw  = gie & irq_sw & mie_sw;
  assign e_tim = gie & irq_timer & mie_timer;

  always_comb begin
    take    = 1'b1;
    is_irq  = 1'b0;
    is_mret = 1'b0;
    code    = 5'd0;
    priority case (1'b1)
      exc_req: code = exc_code;
      e_ext: begin
        is_irq = 1'b1;
        code   = IRQ_MEI;
      end
      e_sw: begin
        is_irq = 1'b1;
        code   = IRQ_MSI;
      end
      e_tim: begin
        is_irq = 1'b1;
        code   = IRQ_MTI;
      end
      mret_req: is_mret = 1'b1;
      default:  take = 1'b0;
    endcase
  end

endmodule

// File: rtl/csr_trap_sequencer.sv
// Trap/MRET sequencer driving the CSR write port and fetch redirect.
// Ports: requests, irq lines, CSR values in; CSR write, stall, redirect out.
module csr_trap_sequencer
  import csr_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exc_req,
  input  logic [4:0]      exc_code,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] cur_pc,
  input  logic            mret_req,
  input  logic            irq_ext,
  input  logic            irq_sw,
  input  logic            irq_timer,
  input  logic [XLEN-1:0] mstatus_q,
  input  logic [XLEN-1:0] mie_q,
  input  logic [XLEN-1:0] mtvec_q,
  input  logic [XLEN-1:0] mepc_q,
  output logic [11:0]     csr_addr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            csr_we,
  output logic            stall,
  output logic            trap_ack,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  trap_state_t state;

  logic            take;
  logic            is_irq;
  logic            is_mret;
  logic [4:0]      code;

  logic [XLEN-1:0] epc_r;
  logic [XLEN-1:0] cause_r;
  logic [XLEN-1:0] status_r;
  logic [XLEN-1:0] tvec_r;

  logic [XLEN-1:0] epc_in;
  logic [XLEN-1:0] tvec_base;
  logic [XLEN-1:0] tvec_off;
  logic [XLEN-1:0] trap_pc;
  logic            vec_hit;
  logic            unused_ok;

  assign unused_ok = ^mie_q;

  trap_arbiter u_arb (
    .exc_req   (exc_req),
    .exc_code  (exc_code),
    .mret_req  (mret_req),
    .irq_ext   (irq_ext),
    .irq_sw    (irq_sw),
    .irq_timer (irq_timer),
    .gie       (mstatus_q[MS_MIE]),
    .mie_ext   (mie_q[IRQ_MEI]),
    .mie_sw    (mie_q[IRQ_MSI]),
    .mie_timer (mie_q[IRQ_MTI]),
    .take      (take),
    .is_irq    (is_irq),
    .is_mret   (is_mret),
    .code      (code)
  );

  function automatic logic [XLEN-1:0] trap_status(
    input logic [XLEN-1:0] s
  );
    logic [XLEN-1:0] r;
    r = s;
    r[MS_MPIE] = s[MS_MIE];
    r[MS_MIE] = 1'b0;
    r[MS_MPP_HI:MS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] mret_status(
    input logic [XLEN-1:0] s
  );
    logic [XLEN-1:0] r;
    r = s;
    r[MS_MIE] = s[MS_MPIE];
    r[MS_MPIE] = 1'b1;
    r[MS_MPP_HI:MS_MPP_LO] = 2'b11;
    return r;
  endfunction

  // MRET reuses epc_r to hold the mepc snapshot.
  always_comb begin
    epc_in = exc_pc;
    if (is_mret)
      epc_in = mepc_q;
    else if (is_irq)
      epc_in = cur_pc;
    epc_in[1:0] = 2'b00;
  end

  assign tvec_base = {tvec_r[XLEN-1:2], 2'b00};
  assign tvec_off  = {{(XLEN-7){1'b0}}, cause_r[4:0], 2'b00};
  assign vec_hit   = VECTORED_EN && (tvec_r[1:0] == 2'b01)
                     && cause_r[XLEN-1];
  assign trap_pc   = vec_hit ? tvec_base + tvec_off : tvec_base;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      epc_r          <= '0;
      cause_r        <= '0;
      status_r       <= '0;
      tvec_r         <= '0;
      csr_addr       <= '0;
      csr_wdata      <= '0;
      csr_we         <= 1'b0;
      stall          <= 1'b0;
      trap_ack       <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      csr_addr       <= '0;
      csr_wdata      <= '0;
      csr_we         <= 1'b0;
      trap_ack       <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      case (state)
        ST_IDLE: begin
          stall <= 1'b0;
          if (take) begin
            epc_r    <= epc_in;
            cause_r  <= {is_irq, {(XLEN-6){1'b0}}, code};
            status_r <= mstatus_q;
            tvec_r   <= mtvec_q;
            stall    <= 1'b1;
            csr_we   <= 1'b1;
            if (is_mret) begin
              state     <= ST_MRET_STATUS;
              csr_addr  <= CSR_MSTATUS;
              csr_wdata <= mret_status(mstatus_q);
            end else begin
              state     <= ST_WR_EPC;
              csr_addr  <= CSR_MEPC;
              csr_wdata <= epc_in;
            end
          end
        end
        ST_WR_EPC: begin
          state     <= ST_WR_CAUSE;
          csr_we    <= 1'b1;
          csr_addr  <= CSR_MCAUSE;
          csr_wdata <= cause_r;
        end
        ST_WR_CAUSE: begin
          state     <= ST_WR_STATUS;
          csr_we    <= 1'b1;
          csr_addr  <= CSR_MSTATUS;
          csr_wdata <= trap_status(status_r);
        end
        ST_WR_STATUS: begin
          state          <= ST_REDIRECT;
          trap_ack       <= 1'b1;
          redirect_valid <= 1'b1;
          redirect_pc    <= trap_pc;
        end
        ST_MRET_STATUS: begin
          state          <= ST_REDIRECT;
          trap_ack       <= 1'b1;
          redirect_valid <= 1'b1;
          redirect_pc    <= epc_r;
        end
        ST_REDIRECT: begin
          state <= ST_IDLE;
          stall <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          stall <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Directed-vector bench for csr_trap_sequencer.
// Drives requests after each edge, checks registered outputs #1 later.
module tb_csr_trap_sequencer;

  logic        clk;
  logic        rst;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic [31:0] cur_pc;
  logic        mret_req;
  logic        irq_ext;
  logic        irq_sw;
  logic        irq_timer;
  logic [31:0] mstatus_q;
  logic [31:0] mie_q;
  logic [31:0] mtvec_q;
  logic [31:0] mepc_q;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_we;
  logic        stall;
  logic        trap_ack;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_vec;
  int n_bad;

  csr_trap_sequencer #(.XLEN(32), .VECTORED_EN(1'b1)) dut (
    .clk            (clk),
    .rst            (rst),
    .exc_req        (exc_req),
    .exc_code       (exc_code),
    .exc_pc         (exc_pc),
    .cur_pc         (cur_pc),
    .mret_req       (mret_req),
    .irq_ext        (irq_ext),
    .irq_sw         (irq_sw),
    .irq_timer      (irq_timer),
    .mstatus_q      (mstatus_q),
    .mie_q          (mie_q),
    .mtvec_q        (mtvec_q),
    .mepc_q         (mepc_q),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .csr_we         (csr_we),
    .stall          (stall),
    .trap_ack       (trap_ack),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".we"}, {31'd0, csr_we}, 32'd0);
    chk({tag, ".stall"}, {31'd0, stall}, 32'd0);
    chk({tag, ".ack"}, {31'd0, trap_ack}, 32'd0);
  endtask

  task automatic chk_wr(input string tag,
                        input logic [11:0] a,
                        input logic [31:0] d);
    chk({tag, ".we"}, {31'd0, csr_we}, 32'd1);
    chk({tag, ".addr"}, {20'd0, csr_addr}, {20'd0, a});
    chk({tag, ".wdata"}, csr_wdata, d);
    chk({tag, ".stall"}, {31'd0, stall}, 32'd1);
    chk({tag, ".ack"}, {31'd0, trap_ack}, 32'd0);
  endtask

  task automatic chk_redir(input string tag, input logic [31:0] pc);
    chk({tag, ".we"}, {31'd0, csr_we}, 32'd0);
    chk({tag, ".addr"}, {20'd0, csr_addr}, 32'd0);
    chk({tag, ".ack"}, {31'd0, trap_ack}, 32'd1);
    chk({tag, ".rv"}, {31'd0, redirect_valid}, 32'd1);
    chk({tag, ".pc"}, redirect_pc, pc);
    chk({tag, ".stall"}, {31'd0, stall}, 32'd1);
  endtask

  // First tick is the acceptance edge; ends on the redirect cycle.
  task automatic run_trap(input string tag,
                          input logic [31:0] epc,
                          input logic [31:0] cause,
                          input logic [31:0] st,
                          input logic [31:0] pc);
    tick();
    chk_wr({tag, ".t1"}, 12'h341, epc);
    tick();
    chk_wr({tag, ".t2"}, 12'h342, cause);
    tick();
    chk_wr({tag, ".t3"}, 12'h300, st);
    tick();
    chk_redir({tag, ".t4"}, pc);
  endtask

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    rst       = 1'b0;
    exc_req   = 1'b0;
    exc_code  = 5'd0;
    exc_pc    = 32'h0;
    cur_pc    = 32'h0;
    mret_req  = 1'b0;
    irq_ext   = 1'b0;
    irq_sw    = 1'b0;
    irq_timer = 1'b0;
    mstatus_q = 32'h0;
    mie_q     = 32'h0;
    mtvec_q   = 32'h0;
    mepc_q    = 32'h0;

    #2;
    chk("rst.we", {31'd0, csr_we}, 32'd0);
    chk("rst.stall", {31'd0, stall}, 32'd0);
    chk("rst.rv", {31'd0, redirect_valid}, 32'd0);
    chk("rst.pc", redirect_pc, 32'd0);
    chk("rst.wdata", csr_wdata, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk_idle("idle0");

    // 1: plain exception, direct vector
    exc_req   = 1'b1;
    exc_code  = 5'd2;
    exc_pc    = 32'h0000_1002;
    mtvec_q   = 32'h8000_0000;
    mstatus_q = 32'h8;
    run_trap("exc", 32'h1000, 32'h2, 32'h1880, 32'h8000_0000);
    exc_req = 1'b0;
    tick();
    chk_idle("exc.post");

    // 2: vectored timer interrupt; inputs change mid-sequence
    irq_timer = 1'b1;
    mie_q     = 32'h80;
    mstatus_q = 32'h8;
    mtvec_q   = 32'h8000_0001;
    cur_pc    = 32'h200;
    tick();
    chk_wr("mti.t1", 12'h341, 32'h200);
    mtvec_q   = 32'h0;
    mstatus_q = 32'h0;
    cur_pc    = 32'hdead_beec;
    tick();
    chk_wr("mti.t2", 12'h342, 32'h8000_0007);
    tick();
    chk_wr("mti.t3", 12'h300, 32'h1880);
    tick();
    chk_redir("mti.t4", 32'h8000_001C);
    irq_timer = 1'b0;
    tick();
    chk_idle("mti.post");

    // 3: exception beats simultaneous irq_ext; irq_ext follows
    exc_req   = 1'b1;
    exc_code  = 5'd5;
    exc_pc    = 32'h0000_2004;
    cur_pc    = 32'h0000_3000;
    irq_ext   = 1'b1;
    mie_q     = 32'h800;
    mstatus_q = 32'h8;
    mtvec_q   = 32'h8000_0001;
    run_trap("pri.exc", 32'h2004, 32'h5, 32'h1880, 32'h8000_0000);
    exc_req = 1'b0;
    tick();
    chk_idle("pri.gap");
    run_trap("pri.mei", 32'h3000, 32'h8000_000B, 32'h1880,
             32'h8000_002C);
    irq_ext = 1'b0;
    tick();
    chk_idle("pri.post");

    // 4: MRET with low-bit masking of mepc
    mret_req  = 1'b1;
    mstatus_q = 32'h1880;
    mepc_q    = 32'h0000_1002;
    tick();
    chk_wr("mret.t1", 12'h300, 32'h1888);
    tick();
    chk_redir("mret.t2", 32'h1000);
    mret_req = 1'b0;
    tick();
    chk_idle("mret.post");

    // 5: software irq masked by mstatus.MIE
    irq_sw    = 1'b1;
    mie_q     = 32'h8;
    mstatus_q = 32'h0;
    cur_pc    = 32'h0000_0406;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("msk.we", {31'd0, csr_we}, 32'd0);
      chk("msk.stall", {31'd0, stall}, 32'd0);
    end
    mstatus_q = 32'h8;
    run_trap("msi", 32'h404, 32'h8000_0003, 32'h1880, 32'h8000_000C);
    irq_sw = 1'b0;
    tick();
    chk_idle("msi.post");

    // 6: async reset during WR_CAUSE
    exc_req   = 1'b1;
    exc_code  = 5'd7;
    exc_pc    = 32'h0000_5000;
    mstatus_q = 32'h8;
    tick();
    chk_wr("rst6.t1", 12'h341, 32'h5000);
    tick();
    chk_wr("rst6.t2", 12'h342, 32'h7);
    #2;
    rst = 1'b0;
    #1;
    chk("rst6.we", {31'd0, csr_we}, 32'd0);
    chk("rst6.addr", {20'd0, csr_addr}, 32'd0);
    chk("rst6.wdata", csr_wdata, 32'd0);
    chk("rst6.stall", {31'd0, stall}, 32'd0);
    exc_req = 1'b0;
    tick();
    chk_idle("rst6.hold1");
    tick();
    chk_idle("rst6.hold2");
    rst = 1'b1;
    tick();
    chk_idle("rst6.rel1");
    tick();
    chk_idle("rst6.rel2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
